// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core memory subsystem.
package segre_pkg;

    localparam int unsigned WORD_SIZE = 32;

    // Access size of a memory operation
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    // Shared memory port arbiter states
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        BUSY_IF  = 2'b01,
        BUSY_MEM = 2'b10,
        DONE     = 2'b11
    } arb_state_e;

    // Consecutive MEM grants allowed while a fetch waits
    localparam int MEM_STREAK_DEFAULT = 4;

    // Request captured at grant time and replayed on the memory port
    typedef struct packed {
        logic [WORD_SIZE-1:0] addr;
        logic [WORD_SIZE-1:0] wdata;
        memop_data_type_e     mtype;
        logic                 rd;
        logic                 wr;
    } mem_req_t;

    // Build a MEM-stage request; a simultaneous read and write resolves to a write
    function automatic mem_req_t make_mem_req(
        input logic [WORD_SIZE-1:0] addr,
        input logic [WORD_SIZE-1:0] wdata,
        input memop_data_type_e     mtype,
        input logic                 rd,
        input logic                 wr
    );
        mem_req_t req;
        req.addr  = addr;
        req.wdata = wdata;
        req.mtype = mtype;
        req.rd    = rd & ~wr;
        req.wr    = wr;
        return req;
    endfunction

    // Build a fetch request: always a full-word read
    function automatic mem_req_t make_fetch_req(input logic [WORD_SIZE-1:0] addr);
        mem_req_t req;
        req.addr  = addr;
        req.wdata = {WORD_SIZE{1'b0}};
        req.mtype = WORD;
        req.rd    = 1'b1;
        req.wr    = 1'b0;
        return req;
    endfunction

endpackage

// File: rtl/segre_arb_streak_cnt.sv
// Saturating counter of consecutive MEM grants taken while a fetch was waiting.
module segre_arb_streak_cnt
    import segre_pkg::*;
#(
    parameter int MAX_CNT = MEM_STREAK_DEFAULT,
    parameter int CNT_W   = 4
) (
    input  logic clk_i,
    input  logic rsn_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic sat_o
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;

    // Clear has priority over increment; increment stops at the limit
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr_i) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc_i && (cnt_r < MAX_C)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign sat_o = (cnt_r >= MAX_C);

endmodule

// File: rtl/segre_mem_arbiter.sv
// Arbiter for the single shared memory port between instruction fetch and the
// MEM stage. MEM wins by default; a streak counter forces a fetch grant after
// MEM_STREAK consecutive MEM wins so fetch always makes progress.
module segre_mem_arbiter
    import segre_pkg::*;
#(
    parameter int MEM_STREAK = MEM_STREAK_DEFAULT,
    parameter int CNT_W      = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    // Instruction fetch side
    input  logic                 if_req_i,
    input  logic [WORD_SIZE-1:0] if_addr_i,
    output logic [WORD_SIZE-1:0] if_data_o,
    output logic                 if_valid_o,
    output logic                 if_stall_o,
    // MEM stage side
    input  logic                 mem_rd_i,
    input  logic                 mem_wr_i,
    input  logic [WORD_SIZE-1:0] mem_addr_i,
    input  logic [WORD_SIZE-1:0] mem_wdata_i,
    input  memop_data_type_e     mem_type_i,
    output logic [WORD_SIZE-1:0] mem_rdata_o,
    output logic                 mem_valid_o,
    output logic                 mem_stall_o,
    // Memory port
    output logic                 m_rd_o,
    output logic                 m_wr_o,
    output logic [WORD_SIZE-1:0] m_addr_o,
    output logic [WORD_SIZE-1:0] m_wdata_o,
    output memop_data_type_e     m_type_o,
    input  logic [WORD_SIZE-1:0] m_rdata_i,
    input  logic                 m_ready_i
);

    arb_state_e           state_r;
    arb_state_e           next_state_s;
    mem_req_t             req_r;
    logic                 owner_if_r;
    logic [WORD_SIZE-1:0] if_data_r;
    logic [WORD_SIZE-1:0] mem_rdata_r;

    logic mem_req_s;
    logic grant_mem_s;
    logic grant_if_s;
    logic streak_sat_s;
    logic busy_s;
    logic done_s;

    assign mem_req_s = mem_rd_i | mem_wr_i;
    assign busy_s    = (state_r == BUSY_IF) || (state_r == BUSY_MEM);
    assign done_s    = (state_r == DONE);

    // Grant decision and state sequencing
    always_comb begin
        next_state_s = state_r;
        grant_mem_s  = 1'b0;
        grant_if_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_req_s && (!streak_sat_s || !if_req_i)) begin
                    grant_mem_s  = 1'b1;
                    next_state_s = BUSY_MEM;
                end else if (if_req_i) begin
                    grant_if_s   = 1'b1;
                    next_state_s = BUSY_IF;
                end else begin
                    next_state_s = IDLE;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (m_ready_i) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = state_r;
                end
            end
            // One retire cycle: the requester drops or replaces its request here
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, latched request and returned data
    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            state_r     <= IDLE;
            req_r       <= '0;
            owner_if_r  <= 1'b0;
            if_data_r   <= {WORD_SIZE{1'b0}};
            mem_rdata_r <= {WORD_SIZE{1'b0}};
        end else begin
            state_r <= next_state_s;
            if (grant_mem_s) begin
                req_r      <= make_mem_req(mem_addr_i, mem_wdata_i, mem_type_i, mem_rd_i, mem_wr_i);
                owner_if_r <= 1'b0;
            end else if (grant_if_s) begin
                req_r      <= make_fetch_req(if_addr_i);
                owner_if_r <= 1'b1;
            end else begin
                req_r      <= req_r;
                owner_if_r <= owner_if_r;
            end
            if ((state_r == BUSY_IF) && m_ready_i) begin
                if_data_r <= m_rdata_i;
            end else begin
                if_data_r <= if_data_r;
            end
            // Stores leave the last load data in place
            if ((state_r == BUSY_MEM) && m_ready_i && req_r.rd) begin
                mem_rdata_r <= m_rdata_i;
            end else begin
                mem_rdata_r <= mem_rdata_r;
            end
        end
    end

    segre_arb_streak_cnt #(
        .MAX_CNT (MEM_STREAK),
        .CNT_W   (CNT_W)
    ) u_streak_cnt (
        .clk_i (clk_i),
        .rsn_i (rsn_i),
        .clr_i (grant_if_s | (grant_mem_s & ~if_req_i)),
        .inc_i (grant_mem_s & if_req_i),
        .sat_o (streak_sat_s)
    );

    // Memory port is driven purely from the latched request while busy
    assign m_rd_o    = busy_s & req_r.rd;
    assign m_wr_o    = busy_s & req_r.wr;
    assign m_addr_o  = busy_s ? req_r.addr  : {WORD_SIZE{1'b0}};
    assign m_wdata_o = busy_s ? req_r.wdata : {WORD_SIZE{1'b0}};
    assign m_type_o  = busy_s ? req_r.mtype : WORD;

    assign if_data_o   = if_data_r;
    assign mem_rdata_o = mem_rdata_r;
    assign if_valid_o  = done_s & owner_if_r;
    assign mem_valid_o = done_s & ~owner_if_r;
    assign if_stall_o  = if_req_i & ~if_valid_o;
    assign mem_stall_o = mem_req_s & ~mem_valid_o;

endmodule
